data_mem_ls: RTL and testbench

- Parametrised byte-addressable data memory with a MIPS-style load/store front end.
- Supports sized accesses (byte, half, word) with per-byte write lanes and sign or zero extension on loads.
- Flags misaligned, out-of-range and reserved-size accesses.
- Sweeps the whole array to a known pattern after every reset.
- Sits between the execute stage and the MEM/WB register of the single-cycle/pipelined CPU; replaces the word-only data memory.

---
 rtl/data_mem_ls.sv | 118 +++++++++++
 tb/tb_data_mem_ls.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ls.sv
// Byte-addressable data memory with sized MIPS-style loads/stores and a post-reset sweep.
// Loads have 1-cycle latency (D_out/rvalid registered); ready is low during the sweep, with no back-pressure in RUN.
module data_mem_ls #(
    parameter int DEPTH     = 256,
    parameter int INIT_MODE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        WE,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] A_in,
    input  logic [31:0] D_in,
    output logic        ready,
    output logic [31:0] D_out,
    output logic        rvalid,
    output logic        fault
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [31:0]   mem [DEPTH];

    logic          acc;
    logic          bad;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_dat;
    logic [31:0]   st_dat;
    logic [3:0]    st_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
    end

    always_comb begin
        ready = (state == ST_RUN);
    end

    // Upper address bits are range-checked rather than dropped, so aliasing can't occur.
    always_comb begin
        acc = req && ready;
        idx = A_in[AW+1:2];
        bad = (size == 2'b11)
           || (size == 2'b01 && A_in[0])
           || (size == 2'b10 && A_in[1:0] != 2'b00)
           || (A_in[31:2] >= 30'(DEPTH));
    end

    always_comb begin
        rd_word = mem[idx];
        ld_byte = rd_word[{A_in[1:0], 3'b000} +: 8];
        ld_half = A_in[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   ld_dat = uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_dat = uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_dat = rd_word;
        endcase
    end

    // Store data is replicated across lanes; the lane mask picks which ones land.
    always_comb begin
        case (size)
            2'b00: begin
                st_dat  = {4{D_in[7:0]}};
                st_lane = 4'b0001 << A_in[1:0];
            end
            2'b01: begin
                st_dat  = {2{D_in[15:0]}};
                st_lane = A_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_dat  = D_in;
                st_lane = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= (INIT_MODE != 0) ? 32'(cnt) : 32'd0;
        end else if (acc && WE && !bad) begin
            for (int k = 0; k < 4; k++) begin
                if (st_lane[k]) mem[idx][8*k +: 8] <= st_dat[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_out  <= '0;
            rvalid <= 1'b0;
            fault  <= 1'b0;
        end else begin
            rvalid <= acc && !WE && !bad;
            fault  <= acc && bad;
            if (acc && !WE && !bad) D_out <= ld_dat;
        end
    end
endmodule

// File: tb/tb_data_mem_ls.sv
// Randomized bench for data_mem_ls against a byte-array reference model.
module tb_data_mem_ls;
    localparam int DEPTH = 16;
    localparam int NBYTE = DEPTH * 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   = 1'b0;
    logic        WE    = 1'b0;
    logic [1:0]  size  = 2'b00;
    logic        uns   = 1'b0;
    logic [31:0] A_in  = '0;
    logic [31:0] D_in  = '0;
    logic        ready;
    logic [31:0] D_out;
    logic        rvalid;
    logic        fault;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  ref_mem [NBYTE];
    logic [31:0] ref_dout;

    data_mem_ls #(.DEPTH(DEPTH), .INIT_MODE(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .WE     (WE),
        .size   (size),
        .uns    (uns),
        .A_in   (A_in),
        .D_in   (D_in),
        .ready  (ready),
        .D_out  (D_out),
        .rvalid (rvalid),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory image after a sweep: word w holds the value w.
    task automatic ref_fill();
        for (int w = 0; w < DEPTH; w++) begin
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = (b == 0) ? 8'(w) : 8'h00;
        end
        ref_dout = '0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic        e_ft;
        logic        e_rv;
        int          nb;
        int          a;
        logic [31:0] v;
        req = 1'b1; WE = we; size = sz; uns = u; A_in = addr; D_in = data;
        nb   = 1 << sz;
        e_ft = (sz == 2'd3) || ((addr % nb) != 0) || (addr >= 32'(NBYTE));
        e_rv = !e_ft && !we;
        if (!e_ft) begin
            a = int'(addr);
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[a+i] = data[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a+i];
                if (!u && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
                if (!u && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
                ref_dout = v;
            end
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        chk({tag, ".fault"},  32'(fault),  32'(e_ft));
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(e_rv));
        chk({tag, ".dout"},   D_out,       ref_dout);
    endtask

    task automatic do_idle(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 32'(rvalid | fault), 32'd0);
        chk({tag, ".dout"},  D_out, ref_dout);
    endtask

    // Counts posedges after reset release until ready rises; -1 on timeout.
    task automatic wait_ready(output int n, output logic noisy);
        n = -1;
        noisy = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            noisy = noisy | rvalid | fault;
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic        noisy;
        int          r;
        logic [31:0] addr;

        #1 rst_n = 1'b0;
        #1;
        chk("rst.ready",  32'(ready),  32'd0);
        chk("rst.dout",   D_out,       32'd0);
        chk("rst.rvalid", 32'(rvalid), 32'd0);
        chk("rst.fault",  32'(fault),  32'd0);

        #10 rst_n = 1'b1;
        wait_ready(lat, noisy);
        chk("init.latency", 32'(lat), 32'(DEPTH));
        chk("init.quiet",   32'(noisy), 32'd0);
        ref_fill();

        do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, "lw00");
        chk("lw00.val", D_out, 32'h0000_0000);
        do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, "lw3c");
        chk("lw3c.val", D_out, 32'h0000_000F);

        do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'h1122_3344, "sw08");
        do_req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, "lb09");
        chk("lb09.val", D_out, 32'h0000_0033);
        do_req(1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, "lbu0b");
        chk("lbu0b.val", D_out, 32'h0000_0011);
        do_req(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, "lh0a");
        chk("lh0a.val", D_out, 32'h0000_1122);
        do_req(1'b0, 2'd1, 1'b1, 32'h08, 32'h0, "lhu08");
        chk("lhu08.val", D_out, 32'h0000_3344);

        do_req(1'b1, 2'd2, 1'b0, 32'h04, 32'h0000_00F0, "sw04");
        do_req(1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_0080, "sb06");
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, "lw04");
        chk("lw04.val", D_out, 32'h0080_00F0);
        do_req(1'b0, 2'd0, 1'b0, 32'h06, 32'h0, "lb06");
        chk("lb06.val", D_out, 32'hFFFF_FF80);

        do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, "flt_lw02");
        do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'hAAAA_5555, "flt_sh03");
        do_req(1'b1, 2'd3, 1'b0, 32'h00, 32'h1234_5678, "flt_sz3");
        do_req(1'b0, 2'd2, 1'b0, 32'(NBYTE), 32'h0, "flt_oor");
        chk("flt.dout_held", D_out, 32'hFFFF_FF80);
        do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, "flt_after");
        chk("flt_after.val", D_out, 32'h0000_0000);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "b2b_sw");
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "b2b_lw");
        chk("b2b.val", D_out, 32'hDEAD_BEEF);

        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       addr = 32'($urandom_range(0, NBYTE - 1));
            else if (r == 8) addr = 32'(NBYTE + $urandom_range(0, 255));
            else             addr = $urandom;
            if ($urandom_range(0, 7) == 0) do_idle("rnd_idle");
            else do_req(1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom, "rnd");
        end

        do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFE_F00D, "pre_sw14");
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h0BAD_0BAD, "pre_sw10");
        req = 1'b1; WE = 1'b0; size = 2'd2; uns = 1'b0; A_in = 32'h14; D_in = '0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.rvalid", 32'(rvalid), 32'd0);
        chk("mid.fault",  32'(fault),  32'd0);
        chk("mid.ready",  32'(ready),  32'd0);
        chk("mid.dout",   D_out,       32'd0);
        WE = 1'b1; A_in = 32'h1C; D_in = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(lat, noisy);
        req = 1'b0;
        chk("reinit.latency", 32'(lat), 32'(DEPTH));
        chk("reinit.quiet",   32'(noisy), 32'd0);
        ref_fill();
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, "reinit_lw14");
        chk("reinit_lw14.val", D_out, 32'h0000_0005);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "reinit_lw10");
        chk("reinit_lw10.val", D_out, 32'h0000_0004);
        do_req(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, "reinit_lw1c");
        chk("reinit_lw1c.val", D_out, 32'h0000_0007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
